// File: rtl/debug_ram_loader.sv
// debug_ram_loader: byte-stream debug port that loads the instruction and data
// BRAMs through their second ports, dumps the data BRAM back out, and pulses
// the core reset. Frame: cmd, count_hi, count_lo, payload (run has no count).
module debug_ram_loader #(
  parameter int unsigned BRAMWORDS  = 4096,
  parameter int unsigned RST_CYCLES = 5
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] inst_a2,
  output logic [31:0] inst_wd2,
  output logic [3:0]  inst_we2,
  output logic [31:0] data_a2,
  output logic [31:0] data_wd2,
  output logic [3:0]  data_we2,
  input  logic [31:0] data_rd2,
  output logic        cpu_rst,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W     = 13;
  localparam int unsigned CNT_RAW_W = 12;
  localparam int unsigned RUN_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [7:0] CMD_LOAD_INST = 8'h01;
  localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
  localparam logic [7:0] CMD_DUMP      = 8'h03;
  localparam logic [7:0] CMD_RUN       = 8'h04;

  // Low two bits of the accepted command select the target.
  localparam logic [1:0] KIND_INST = 2'b01;
  localparam logic [1:0] KIND_DUMP = 2'b11;

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, BYTE, WRITE, RUN, RD_ADDR, RD_WAIT, TX
  } stateType;

  stateType             state;
  stateType             nextState;
  logic [1:0]           cmdKind;
  logic [3:0]           cntHi;
  logic [IDX_W-1:0]     count;
  logic [IDX_W-1:0]     wordIndex;
  logic [IDX_W-1:0]     idxInc;
  logic [IDX_W-1:0]     rdIdx;
  logic [1:0]           byteCnt;
  logic [23:0]          asmBytes;
  logic [23:0]          txBytes;
  logic [31:0]          asmWord;
  logic [RUN_W-1:0]     runCnt;
  logic                 rxFire;
  logic                 txFire;
  logic                 lastWord;
  logic                 cmdHasCount;
  logic [CNT_RAW_W-1:0] countRaw;
  logic [IDX_W-1:0]     countSel;
  logic                 rxReadyNext;
  logic                 txValidNext;
  logic                 cpuRstNext;
  logic                 busyNext;
  logic [3:0]           instWeNext;
  logic [3:0]           dataWeNext;

  // Byte address of a word index.
  function automatic logic [31:0] wordAddr(input logic [IDX_W-1:0] idx);
    return 32'({idx, 2'b00});
  endfunction

  assign rxFire      = rx_valid & rx_ready;
  assign txFire      = tx_valid & tx_ready;
  assign idxInc      = wordIndex + IDX_W'(1);
  assign lastWord    = (idxInc == count);
  assign cmdHasCount = (rx_data == CMD_LOAD_INST) || (rx_data == CMD_LOAD_DATA) ||
                       (rx_data == CMD_DUMP);
  assign countRaw    = {cntHi, rx_data};
  // A zero count (or one larger than the RAM) means the whole RAM.
  assign countSel    = ((countRaw == '0) || (IDX_W'(countRaw) > IDX_W'(BRAMWORDS))) ?
                       IDX_W'(BRAMWORDS) : IDX_W'(countRaw);
  // Little-endian assembly: the byte arriving now becomes the top byte.
  assign asmWord     = {rx_data, asmBytes};
  // Dump address: the next word when leaving TX, else the current one.
  assign rdIdx       = (state == TX) ? idxInc : wordIndex;

  // State register.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) state <= IDLE;
    else            state <= nextState;
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (rxFire) begin
          if (rx_data == CMD_RUN) nextState = RUN;
          else if (cmdHasCount)   nextState = CNT_HI;
        end
      end
      CNT_HI:  if (rxFire) nextState = CNT_LO;
      CNT_LO:  if (rxFire) nextState = (cmdKind == KIND_DUMP) ? RD_ADDR : BYTE;
      BYTE:    if (rxFire && (byteCnt == 2'd3)) nextState = WRITE;
      WRITE:   nextState = lastWord ? IDLE : BYTE;
      RUN:     if (runCnt == RUN_W'(RST_CYCLES - 1)) nextState = IDLE;
      RD_ADDR: nextState = RD_WAIT;
      RD_WAIT: nextState = TX;
      TX:      if (txFire && (byteCnt == 2'd3)) nextState = lastWord ? IDLE : RD_ADDR;
      default: nextState = IDLE;
    endcase
  end

  // Output decode of the upcoming state; registered below so outputs track state.
  always_comb begin
    rxReadyNext = 1'b0;
    txValidNext = 1'b0;
    cpuRstNext  = 1'b0;
    busyNext    = (nextState != IDLE);
    instWeNext  = 4'h0;
    dataWeNext  = 4'h0;
    case (nextState)
      IDLE, CNT_HI, CNT_LO, BYTE: rxReadyNext = 1'b1;
      WRITE: begin
        if (cmdKind == KIND_INST) instWeNext = 4'hF;
        else                      dataWeNext = 4'hF;
      end
      RUN:     cpuRstNext  = 1'b1;
      TX:      txValidNext = 1'b1;
      default: ;
    endcase
  end

  // Output registers; RAM address/data hold between transactions.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      inst_a2  <= 32'h0;
      inst_wd2 <= 32'h0;
      inst_we2 <= 4'h0;
      data_a2  <= 32'h0;
      data_wd2 <= 32'h0;
      data_we2 <= 4'h0;
    end else begin
      rx_ready <= rxReadyNext;
      tx_valid <= txValidNext;
      cpu_rst  <= cpuRstNext;
      busy     <= busyNext;
      inst_we2 <= instWeNext;
      data_we2 <= dataWeNext;
      if (nextState == WRITE) begin
        if (cmdKind == KIND_INST) begin
          inst_a2  <= wordAddr(wordIndex);
          inst_wd2 <= asmWord;
        end else begin
          data_a2  <= wordAddr(wordIndex);
          data_wd2 <= asmWord;
        end
      end
      if (nextState == RD_ADDR) data_a2 <= wordAddr(rdIdx);
      if (state == RD_WAIT)     tx_data <= data_rd2[7:0];
      else if (txFire)          tx_data <= txBytes[7:0];
    end
  end

  // Datapath: command capture, counters, byte assembly and readback shifter.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      cmdKind   <= 2'b00;
      cntHi     <= 4'h0;
      count     <= '0;
      wordIndex <= '0;
      byteCnt   <= 2'd0;
      asmBytes  <= 24'h0;
      txBytes   <= 24'h0;
      runCnt    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rxFire) begin
            wordIndex <= '0;
            byteCnt   <= 2'd0;
            runCnt    <= '0;
            if (cmdHasCount)            cmdKind <= rx_data[1:0];
            else if (rx_data != CMD_RUN) err    <= 1'b1;
          end
        end
        CNT_HI: if (rxFire) cntHi <= rx_data[3:0];
        CNT_LO: if (rxFire) count <= countSel;
        BYTE: begin
          if (rxFire) begin
            asmBytes <= asmWord[31:8];
            byteCnt  <= byteCnt + 2'd1;
          end
        end
        WRITE:   wordIndex <= idxInc;
        RUN:     runCnt    <= runCnt + RUN_W'(1);
        RD_WAIT: txBytes   <= data_rd2[31:8];
        TX: begin
          if (txFire) begin
            txBytes <= {8'h00, txBytes[23:8]};
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) wordIndex <= idxInc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ram_loader.sv
// tb_debug_ram_loader: table of command frames plus hand-written reset and
// full-RAM sequences; RAM writes and readback bytes go through scoreboards.
module tb_debug_ram_loader;

  localparam int unsigned WORDS = 4096;
  localparam int unsigned RSTC  = 5;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] inst_a2;
  logic [31:0] inst_wd2;
  logic [3:0]  inst_we2;
  logic [31:0] data_a2;
  logic [31:0] data_wd2;
  logic [3:0]  data_we2;
  logic [31:0] data_rd2;
  logic        cpu_rst;
  logic        busy;
  logic        err;

  debug_ram_loader #(.BRAMWORDS(WORDS), .RST_CYCLES(RSTC)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inst_a2(inst_a2), .inst_wd2(inst_wd2), .inst_we2(inst_we2),
    .data_a2(data_a2), .data_wd2(data_wd2), .data_we2(data_we2), .data_rd2(data_rd2),
    .cpu_rst(cpu_rst), .busy(busy), .err(err)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Synchronous BRAM models (1-cycle read latency on the data RAM).
  logic [31:0] imem [WORDS];
  logic [31:0] dmem [WORDS];
  logic        presetEn;
  logic [11:0] presetIdx;
  logic [31:0] presetVal;

  always @(posedge CPU_CLK) begin
    if (presetEn) dmem[presetIdx] <= presetVal;
    if (inst_we2 == 4'hF) imem[inst_a2[13:2]] <= inst_wd2;
    if (data_we2 == 4'hF) dmem[data_a2[13:2]] <= data_wd2;
    data_rd2 <= dmem[data_a2[13:2]];
  end

  typedef struct packed {
    logic        isInst;
    logic [31:0] addr;
    logic [31:0] data;
  } wrT;

  typedef struct {
    logic [7:0]  cmd;
    logic [11:0] cnt;
    logic [3:0]  hiJunk;
    logic [31:0] seed;
    int          txMode;
    logic        expErr;
    int          expWords;
  } vecT;

  localparam int NVEC = 12;
  vecT         vecs [NVEC];
  wrT          wrQ [$];
  logic [7:0]  txQ [$];
  logic [31:0] shadow [WORDS];

  int          compared = 0;
  int          mismatched = 0;
  int          txMode = 0;
  logic        lastRxFire = 1'b0;
  logic        sBusy = 1'b0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevTxData = 8'h00;
  int          runLen = 0;
  int          runBad = 0;
  int          wrCount = 0;
  logic [31:0] lastWrAddr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] patWord(input logic [31:0] seed, input int i);
    return (seed + 32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Negedge monitor: scoreboard pops for RAM writes and tx bytes.
  task automatic sample();
    wrT   e;
    logic isInst;
    lastRxFire = rx_valid && rx_ready;
    sBusy      = busy;
    if (!CPU_RST_N) begin
      prevStall = 1'b0;
      return;
    end
    if (cpu_rst) begin
      runLen++;
      if (!busy || rx_ready) runBad++;
    end
    if (inst_we2 != 4'h0 || data_we2 != 4'h0) begin
      check("wr_expected", 32'(wrQ.size() != 0), 32'd1);
      if (wrQ.size() != 0) begin
        e = wrQ.pop_front();
        isInst = (inst_we2 != 4'h0);
        check("wr_target", 32'(isInst), 32'(e.isInst));
        check("wr_we", 32'(isInst ? inst_we2 : data_we2), 32'hF);
        check("wr_addr", isInst ? inst_a2 : data_a2, e.addr);
        check("wr_data", isInst ? inst_wd2 : data_wd2, e.data);
      end
      wrCount++;
      lastWrAddr = (inst_we2 != 4'h0) ? inst_a2 : data_a2;
    end
    if (prevStall) begin
      check("tx_hold_valid", 32'(tx_valid), 32'd1);
      check("tx_hold_data", 32'(tx_data), 32'(prevTxData));
    end
    if (tx_valid && tx_ready) begin
      check("tx_expected", 32'(txQ.size() != 0), 32'd1);
      if (txQ.size() != 0) check("tx_byte", 32'(tx_data), 32'(txQ.pop_front()));
    end
    prevStall  = tx_valid && !tx_ready;
    prevTxData = tx_data;
  endtask

  // One clock: sample at negedge, then drive tx_ready just after the rising edge.
  task automatic cycle();
    @(negedge CPU_CLK);
    sample();
    @(posedge CPU_CLK);
    #1;
    case (txMode)
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      cycle();
      n++;
    end while (!lastRxFire && n < 200);
    if (!lastRxFire) check("rx_accept_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int b = 0; b < 4; b++) sendByte(w[8*b +: 8]);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (sBusy && n < 3000);
    check("idle_timeout", 32'(sBusy), 32'd0);
  endtask

  task automatic pushWr(input logic isInst, input logic [31:0] addr, input logic [31:0] data);
    wrT e;
    e.isInst = isInst;
    e.addr   = addr;
    e.data   = data;
    wrQ.push_back(e);
  endtask

  task automatic runVector(input vecT v);
    logic [31:0] w;
    runLen = 0;
    runBad = 0;
    txMode = v.txMode;
    sendByte(v.cmd);
    if (v.cmd == 8'h03) begin
      for (int i = 0; i < v.expWords; i++)
        for (int b = 0; b < 4; b++) txQ.push_back(shadow[i][8*b +: 8]);
    end
    if (v.cmd >= 8'h01 && v.cmd <= 8'h03) begin
      sendByte({v.hiJunk, v.cnt[11:8]});
      sendByte(v.cnt[7:0]);
    end
    if (v.cmd == 8'h01 || v.cmd == 8'h02) begin
      for (int i = 0; i < v.expWords; i++) begin
        w = patWord(v.seed, i);
        pushWr(v.cmd == 8'h01, 32'(i * 4), w);
        if (v.cmd == 8'h02) shadow[i] = w;
        send4(w);
      end
    end
    waitIdle();
    txMode = 0;
    check("vec_err", 32'(err), 32'(v.expErr));
    check("vec_run_len", 32'(runLen), (v.cmd == 8'h04) ? 32'(RSTC) : 32'd0);
    check("vec_run_busy_rdy", 32'(runBad), 32'd0);
    check("vec_wr_left", 32'(wrQ.size()), 32'd0);
    check("vec_tx_left", 32'(txQ.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'h01, 12'd3,     4'hA, 32'h1111_0000, 0, 1'b0, 3};
    vecs[1]  = '{8'h02, 12'd5,     4'h0, 32'h2222_0000, 0, 1'b0, 5};
    vecs[2]  = '{8'h03, 12'd5,     4'hF, 32'h0,         1, 1'b0, 5};
    vecs[3]  = '{8'h01, 12'd1,     4'h0, 32'h3333_0000, 0, 1'b0, 1};
    vecs[4]  = '{8'h03, 12'd2,     4'h0, 32'h0,         2, 1'b0, 2};
    vecs[5]  = '{8'h04, 12'd0,     4'h0, 32'h0,         0, 1'b0, 0};
    vecs[6]  = '{8'h7F, 12'd0,     4'h0, 32'h0,         0, 1'b1, 0};
    vecs[7]  = '{8'h04, 12'd0,     4'h0, 32'h0,         0, 1'b1, 0};
    vecs[8]  = '{8'h02, 12'd2,     4'h0, 32'h4444_0000, 2, 1'b1, 2};
    vecs[9]  = '{8'h00, 12'd0,     4'h0, 32'h0,         0, 1'b1, 0};
    vecs[10] = '{8'h02, 12'h101,   4'h5, 32'h5555_0000, 0, 1'b1, 257};
    vecs[11] = '{8'h03, 12'h101,   4'h9, 32'h0,         2, 1'b1, 257};

    CPU_RST_N = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_ready  = 1'b1;
    presetEn  = 1'b0;
    presetIdx = 12'h0;
    presetVal = 32'h0;
    for (int i = 0; i < WORDS; i++) shadow[i] = 32'h0;

    // Reset values while held.
    repeat (3) @(posedge CPU_CLK);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we2", 32'({inst_we2, data_we2}), 32'd0);
    check("rst_inst_a2_wd2", inst_a2 | inst_wd2, 32'd0);
    check("rst_data_a2_wd2", data_a2 | data_wd2, 32'd0);

    // Release: cpu_rst drops and rx_ready rises on the first edge.
    CPU_RST_N = 1'b1;
    #1;
    check("rel_cpu_rst_pre", 32'(cpu_rst), 32'd1);
    check("rel_rx_ready_pre", 32'(rx_ready), 32'd0);
    cycle();
    check("rel_cpu_rst_post", 32'(cpu_rst), 32'd0);
    check("rel_rx_ready_post", 32'(rx_ready), 32'd1);

    // Two-word instruction load.
    pushWr(1'b1, 32'h0, 32'h0000_0013);
    pushWr(1'b1, 32'h4, 32'h0010_0093);
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h02);
    send4(32'h0000_0013);
    send4(32'h0010_0093);
    waitIdle();
    check("load2_wr_left", 32'(wrQ.size()), 32'd0);
    check("load2_a2_hold", inst_a2, 32'h4);
    check("load2_we_idle", 32'(inst_we2), 32'd0);

    // Dump of a preset word with tx_ready toggling.
    presetIdx = 12'h0;
    presetVal = 32'hDEAD_BEEF;
    presetEn  = 1'b1;
    cycle();
    presetEn  = 1'b0;
    shadow[0] = 32'hDEAD_BEEF;
    txQ.push_back(8'hEF); txQ.push_back(8'hBE);
    txQ.push_back(8'hAD); txQ.push_back(8'hDE);
    txMode = 1;
    sendByte(8'h03); sendByte(8'h00); sendByte(8'h01);
    waitIdle();
    txMode = 0;
    check("dump1_tx_left", 32'(txQ.size()), 32'd0);
    check("dump1_a2_hold", data_a2, 32'h0);

    for (int v = 0; v < NVEC; v++) runVector(vecs[v]);

    // Reset in the middle of a word: no write, err cleared, next load starts at 0.
    check("pre_abort_err", 32'(err), 32'd1);
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hAA); sendByte(8'hBB);
    cycle();
    CPU_RST_N = 1'b0;
    #1;
    check("abort_err", 32'(err), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) cycle();
    CPU_RST_N = 1'b1;
    cycle();
    pushWr(1'b1, 32'h0, 32'h4433_2211);
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h01);
    send4(32'h4433_2211);
    waitIdle();
    check("abort_wr_left", 32'(wrQ.size()), 32'd0);
    check("abort_err_after", 32'(err), 32'd0);

    // Count 0 loads the whole data RAM without wrapping.
    wrCount = 0;
    sendByte(8'h02); sendByte(8'h00); sendByte(8'h00);
    for (int i = 0; i < WORDS; i++) begin
      pushWr(1'b0, 32'(i * 4), patWord(32'h6666_0000, i));
      send4(patWord(32'h6666_0000, i));
    end
    waitIdle();
    check("full_wr_count", 32'(wrCount), 32'(WORDS));
    check("full_last_addr", lastWrAddr, 32'h3FFC);
    check("full_wr_left", 32'(wrQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/debug_ram_loader.md
DEBUG_RAM_LOADER -- requirements
Module: debug_ram_loader

Interface
REQ-001 SHALL have parameter BRAMWORDS, default 4096, meaning words per RAM (32-bit each).
REQ-002 SHALL have parameter RST_CYCLES, default 5, meaning CPU_RST pulse length in clocks.
REQ-003 SHALL have CPU_CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have CPU_RST_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have rx_data  in  8  command/payload byte stream.
REQ-006 SHALL have rx_valid  in  1 and rx_ready  out  1  byte handshake; a byte transfers on a rising edge with both high.
REQ-007 SHALL have tx_data  out  8, tx_valid  out  1, tx_ready  in  1  readback byte stream, same handshake rule.
REQ-008 SHALL have inst_a2  out  32, inst_wd2  out  32, inst_we2  out  4  driving CPU_Debug_InstRAM_A2/WD2/WE2.
REQ-009 SHALL have data_a2  out  32, data_wd2  out  32, data_we2  out  4, data_rd2  in  32  driving CPU_Debug_DataRAM_A2/WD2/WE2 and reading RD2.
REQ-010 SHALL have cpu_rst  out  1  active-high reset to RV32Core CPU_RST.
REQ-011 SHALL have busy  out  1 (state != IDLE) and err  out  1 (sticky bad-command flag).

Function
REQ-012 Protocol SHALL be: command byte, count_hi, count_lo, then payload; count = {count_hi[3:0],count_lo}, with 0 meaning BRAMWORDS; count_hi[7:4] ignored.
REQ-013 Commands SHALL be: 0x01 load InstRAM, 0x02 load DataRAM, 0x03 dump DataRAM, 0x04 run (no count bytes).
REQ-014 Any other command byte SHALL be consumed, set err, and leave the FSM in IDLE; err clears only on reset.
REQ-015 FSM states SHALL be IDLE, CNT_HI, CNT_LO, BYTE, WRITE, RUN, RD_ADDR, RD_WAIT, TX.
REQ-016 IDLE->CNT_HI on 0x01-0x03; IDLE->RUN on 0x04; CNT_HI->CNT_LO->(BYTE for load, RD_ADDR for dump) on each accepted byte.
REQ-017 Load payload SHALL be 4 bytes per word, little-endian (first byte = bits 7:0); BYTE->WRITE after the 4th byte.
REQ-018 WRITE SHALL last exactly one cycle with target we2=4'b1111, wd2=assembled word, a2=word_index*4; all other cycles we2=0.
REQ-019 rx_ready SHALL be high only in IDLE, CNT_HI, CNT_LO, BYTE; low in all other states.
REQ-020 After WRITE, word_index increments; if word_index reaches count, FSM SHALL return to IDLE, else to BYTE.
REQ-021 Dump: RD_ADDR drives data_a2=word_index*4 for one cycle; RD_WAIT captures data_rd2 one cycle later (1-cycle synchronous BRAM); TX sends 4 bytes little-endian.
REQ-022 tx_valid SHALL be high only in TX; tx_data SHALL hold stable while tx_valid high and tx_ready low.
REQ-023 After the 4th TX byte, word_index increments; next state RD_ADDR, or IDLE when word_index reaches count.
REQ-024 RUN SHALL hold cpu_rst=1 for exactly RST_CYCLES clocks, then return to IDLE with cpu_rst=0.
REQ-025 word_index SHALL be 13 bits; addresses SHALL never exceed (BRAMWORDS-1)*4; word_index clears on every new command.
REQ-026 inst_a2/data_a2 SHALL hold their last driven value between transactions.

Reset
REQ-027 On CPU_RST_N low, immediately: state=IDLE, all a2/wd2=0, we2=0, rx_ready=0 until reset released, tx_valid=0, tx_data=0, cpu_rst=1, busy=0, err=0.
REQ-028 After CPU_RST_N rises, cpu_rst SHALL deassert on the first rising edge and rx_ready rise on that same edge.
REQ-029 Reset mid-transaction SHALL abort with no further RAM write; a partially assembled word is discarded.

Verification
REQ-030 Load: 01 00 02 | 13 00 00 00 | 93 00 10 00 -> inst_we2=F once at a2=0 wd2=0x00000013, once at a2=4 wd2=0x00100093, then IDLE.
REQ-031 Dump: preset DataRAM[0]=0xDEADBEEF, send 03 00 01 with tx_ready toggling -> tx bytes EF BE AD DE, data_we2 never nonzero.
REQ-032 Run: send 04 -> cpu_rst high exactly 5 cycles, busy high during, rx_ready low during.
REQ-033 Count 0: 02 00 00 + 16384 bytes -> 4096 writes, last at data_a2=0x3FFC, no wrap to 0.
REQ-034 Bad command 0x7F -> err=1, state IDLE; following 04 still executes; err clears only by CPU_RST_N.
REQ-035 Reset after 2 payload bytes of a load -> no write; next 01 00 01 + 4 bytes writes at a2=0.
